// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and sizing helper for the seg_scan display driver.
package seg_pkg;

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_SHOW = 1'b1
    } scan_state_t;

    // Segment byte with every segment and the dp dark, in active-low form.
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low g..a patterns for hex 0..F; bit 7 is replaced by the dp.
    localparam logic [7:0] HEX_TBL [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Value/strobe inputs and segment/digit outputs of the seg_scan display driver.
interface seg_scan_if #(
    parameter int unsigned DIGITS = 8
) ();
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic                load;
    logic [7:0]          seg;
    logic [DIGITS-1:0]   dig;
    logic                frame_done;

    modport master (output data, dp, blank, load, input  seg, dig, frame_done);
    modport slave  (input  data, dp, blank, load, output seg, dig, frame_done);
endinterface

// File: rtl/seg_hex_decode.sv
// Hex nibble to seven-segment byte with decimal point, dark override and polarity.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_dp,
    input  logic       i_dark,
    input  logic       i_active_low,
    output logic [7:0] o_seg_c
);
    logic [7:0] w_low;

    always_comb begin
        w_low   = i_dark ? SEG_OFF : {~i_dp, 7'(HEX_TBL[i_nib])};
        o_seg_c = i_active_low ? w_low : ~w_low;
    end
endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner: slot prescaler, dead-time FSM,
// double-buffered digit values and leading-zero suppression.
module seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS         = 8,
    parameter int unsigned SLOT_CYC       = 50000,
    parameter int unsigned DEAD_CYC       = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1,
    parameter bit          LZ_BLANK       = 1'b0
) (
    input logic       clk,
    input logic       rst,
    seg_scan_if.slave bus
);
    localparam int unsigned       PRE_W     = clog2(SLOT_CYC);
    localparam int unsigned       IDX_W     = (DIGITS > 1) ? clog2(DIGITS) : 1;
    localparam int unsigned       DATA_W    = 4 * DIGITS;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SLOT_CYC - 1);
    localparam logic [PRE_W-1:0]  PRE_ENTER = PRE_W'(DEAD_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] DIG_OFF   = DIG_ACTIVE_LOW ? '1 : '0;
    localparam logic [7:0]        SEG_IDLE  = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
    localparam scan_state_t       ST_RST    = (DEAD_CYC == 0) ? ST_SHOW : ST_DEAD;

    logic [PRE_W-1:0]  r_pre;
    logic [IDX_W-1:0]  r_idx;
    scan_state_t       r_state;
    logic [DATA_W-1:0] r_stg_data, r_shd_data;
    logic [DIGITS-1:0] r_stg_dp, r_shd_dp, r_stg_blank, r_shd_blank;
    logic [7:0]        r_seg;
    logic [DIGITS-1:0] r_dig;
    logic              r_frame_done;

    scan_state_t       w_state_nxt;
    logic              w_pre_wrap, w_bound;
    logic [3:0]        w_nib;
    logic              w_dp, w_dark_sel, w_dark;
    logic [DIGITS-1:0] w_dig_on, w_dig_nxt;
    logic [DIGITS:0]   w_lz;
    logic [7:0]        w_seg_c;

    // State register; the FSM mirrors whether pre has reached the dead-time end.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RST;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pre_wrap  = (r_pre == PRE_LAST);
        w_bound     = w_pre_wrap && (r_idx == IDX_LAST);
        case (r_state)
            ST_DEAD: if (r_pre == PRE_ENTER)                  w_state_nxt = ST_SHOW;
            ST_SHOW: if (w_pre_wrap && (DEAD_CYC != 0))       w_state_nxt = ST_DEAD;
        endcase

        // w_lz[k]: digits DIGITS-1 down to k are all zero with dp clear.
        w_lz         = '0;
        w_lz[DIGITS] = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            w_lz[k] = w_lz[k+1] && (r_shd_data[4*k +: 4] == 4'd0) && !r_shd_dp[k];
        end

        w_nib      = '0;
        w_dp       = 1'b0;
        w_dark_sel = 1'b0;
        w_dig_on   = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib       = r_shd_data[4*k +: 4];
                w_dp        = r_shd_dp[k];
                w_dark_sel  = r_shd_blank[k] || (LZ_BLANK && (k != 0) && w_lz[k]);
                w_dig_on[k] = 1'b1;
            end
        end

        w_dark    = (r_state == ST_DEAD) || w_dark_sel;
        w_dig_nxt = (r_state == ST_SHOW) ? (DIG_ACTIVE_LOW ? ~w_dig_on : w_dig_on) : DIG_OFF;
    end

    seg_hex_decode u_dec (
        .i_nib        (w_nib),
        .i_dp         (w_dp),
        .i_dark       (w_dark),
        .i_active_low (SEG_ACTIVE_LOW),
        .o_seg_c      (w_seg_c)
    );

    // Counters, staging/shadow buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre        <= '0;
            r_idx        <= '0;
            r_stg_data   <= '0;
            r_stg_dp     <= '0;
            r_stg_blank  <= '0;
            r_shd_data   <= '0;
            r_shd_dp     <= '0;
            r_shd_blank  <= '0;
            r_seg        <= SEG_IDLE;
            r_dig        <= DIG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_pre <= w_pre_wrap ? '0 : r_pre + PRE_W'(1);
            if (w_pre_wrap) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            if (bus.load) begin
                r_stg_data  <= bus.data;
                r_stg_dp    <= bus.dp;
                r_stg_blank <= bus.blank;
            end
            // A load on the boundary itself goes straight to the shadow.
            if (w_bound) begin
                r_shd_data  <= bus.load ? bus.data  : r_stg_data;
                r_shd_dp    <= bus.load ? bus.dp    : r_stg_dp;
                r_shd_blank <= bus.load ? bus.blank : r_stg_blank;
            end
            r_frame_done <= w_bound;
            r_seg        <= w_seg_c;
            r_dig        <= w_dig_nxt;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dig        = r_dig;
    assign bus.frame_done = r_frame_done;
endmodule
